// File: rtl/tanh_pwl_pipe.sv
// Multi-lane signed fixed-point tanh: hard clip or 8-segment PWL, 3-stage valid/ready pipe.
// Stages: S1 abs/segment index, S2 slope*fraction, S3 add/sign/saturate.
module tanh_pwl_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_WIDTH = 16,
  parameter int LANES      = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_mode,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] out_data
);

  localparam int AW = DATA_WIDTH - 1;
  localparam int MW = FRAC_WIDTH + 1;
  localparam int PW = 2 * FRAC_WIDTH - 1;
  localparam logic [AW-1:0] ONE_A = AW'(1) << FRAC_WIDTH;
  localparam logic [AW-1:0] SAT_A = AW'(1) << (FRAC_WIDTH + 2);
  localparam logic [MW-1:0] ONE_M = MW'(1) << FRAC_WIDTH;

  // tanh sampled every 0.5 on [0,4], Q0.16, rescaled to the configured fraction width
  function automatic logic [FRAC_WIDTH-1:0] knot(input logic [3:0] idx);
    logic [15:0] q;
    case (idx)
      4'd0:    q = 16'd0;
      4'd1:    q = 16'd30285;
      4'd2:    q = 16'd49912;
      4'd3:    q = 16'd59320;
      4'd4:    q = 16'd63178;
      4'd5:    q = 16'd64659;
      4'd6:    q = 16'd65212;
      4'd7:    q = 16'd65417;
      default: q = 16'd65492;
    endcase
    return FRAC_WIDTH'(q) << (FRAC_WIDTH - 16);
  endfunction

  logic v1, v2, v3;
  logic md1, md2;
  logic adv;

  assign adv       = !v3 || out_ready;
  assign in_ready  = adv;
  assign out_valid = v3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (adv) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
    end
  end

  always_ff @(posedge clk) begin
    if (adv && in_valid) md1 <= in_mode;
    if (adv && v1)       md2 <= md1;
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [DATA_WIDTH-1:0] x;
    logic [AW-1:0]         a;
    logic [MW-1:0]         clip_c;

    logic                  s1_sgn, s1_sat;
    logic [MW-1:0]         s1_clip;
    logic [2:0]            s1_k;
    logic [FRAC_WIDTH-2:0] s1_f;

    logic [FRAC_WIDTH-1:0] base_c, diff_c, prod_c;

    logic                  s2_sgn, s2_sat;
    logic [MW-1:0]         s2_clip;
    logic [FRAC_WIDTH-1:0] s2_base, s2_p;

    logic [MW-1:0]         pwl_c, m_c;
    logic [DATA_WIDTH-1:0] y_c, y_q;

    assign x = in_data[l*DATA_WIDTH +: DATA_WIDTH];

    // most-negative input has no positive twin; pin it to the largest magnitude instead of wrapping
    always_comb begin
      if (!x[DATA_WIDTH-1])
        a = x[AW-1:0];
      else if (x[AW-1:0] == '0)
        a = '1;
      else
        a = ~x[AW-1:0] + AW'(1);
      clip_c = (a >= ONE_A) ? ONE_M : a[MW-1:0];
    end

    always_comb begin
      base_c = knot({1'b0, s1_k});
      diff_c = knot({1'b0, s1_k} + 4'd1) - base_c;
      prod_c = FRAC_WIDTH'((PW'(diff_c) * PW'(s1_f)) >> (FRAC_WIDTH - 1));
    end

    always_comb begin
      pwl_c = MW'(s2_base) + MW'(s2_p);
      if (md2)
        m_c = s2_sat ? ONE_M : pwl_c;
      else
        m_c = s2_clip;
      y_c = DATA_WIDTH'(m_c);
      if (s2_sgn) y_c = -y_c;
    end

    always_ff @(posedge clk) begin
      if (adv && in_valid) begin
        s1_sgn  <= x[DATA_WIDTH-1];
        s1_sat  <= (a >= SAT_A);
        s1_clip <= clip_c;
        s1_k    <= a[FRAC_WIDTH+1:FRAC_WIDTH-1];
        s1_f    <= a[FRAC_WIDTH-2:0];
      end
      if (adv && v1) begin
        s2_sgn  <= s1_sgn;
        s2_sat  <= s1_sat;
        s2_clip <= s1_clip;
        s2_base <= base_c;
        s2_p    <= prod_c;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n)
        y_q <= '0;
      else if (adv && v2)
        y_q <= y_c;
    end

    assign out_data[l*DATA_WIDTH +: DATA_WIDTH] = y_q;
  end

endmodule

// File: tb/tb_tanh_pwl_pipe.sv
// Bench for tanh_pwl_pipe (4 lanes, Q15.16): directed spec points, segment sweep,
// randomized backpressure stream and mid-stream reset, against an arithmetic model.
module tb_tanh_pwl_pipe;
  localparam int DW = 32;
  localparam int FW = 16;
  localparam int L  = 4;
  localparam int BW = DW * L;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, in_mode, out_valid, out_ready;
  logic [BW-1:0] in_data, out_data;

  int errs   = 0;
  int checks = 0;
  int tk [0:8] = '{0, 30285, 49912, 59320, 63178, 64659, 65212, 65417, 65492};

  typedef struct {
    logic [BW-1:0] data;
    bit            mode;
    bit            lit;
    logic [BW-1:0] exp;
  } beat_t;

  beat_t         src_q[$];
  logic [BW-1:0] exp_q[$];

  always #5 clk = ~clk;

  tanh_pwl_pipe #(.DATA_WIDTH(DW), .FRAC_WIDTH(FW), .LANES(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // tanh by the rules: |x| in Q15.16, 0.5-wide segments, linear between knots
  function automatic logic [31:0] ref_tanh(input logic [31:0] x, input bit mode);
    longint xs, a, m, f;
    int     k;
    xs = longint'($signed(x));
    a  = (xs < 0) ? -xs : xs;
    if (a > 64'sd2147483647) a = 64'sd2147483647;
    if (!mode)
      m = (a < 65536) ? a : 65536;
    else if (a >= 262144)
      m = 65536;
    else begin
      k = int'(a / 32768);
      f = a % 32768;
      m = tk[k] + ((tk[k+1] - tk[k]) * f) / 32768;
    end
    if (xs < 0) m = -m;
    return m[31:0];
  endfunction

  function automatic logic [BW-1:0] model(input logic [BW-1:0] d, input bit mode);
    logic [BW-1:0] r;
    for (int l = 0; l < L; l++) r[l*DW +: DW] = ref_tanh(d[l*DW +: DW], mode);
    return r;
  endfunction

  function automatic logic [BW-1:0] pack4(input logic [31:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [31:0] rand_x();
    logic [31:0] r;
    case ($urandom_range(0, 3))
      0:       r = 32'($urandom_range(0, 262143));
      1:       r = $urandom;
      2:       r = 32'($urandom_range(262100, 262200));
      default: r = 32'($urandom_range(65000, 66100));
    endcase
    if ($urandom_range(0, 1) == 1) r = -r;
    return r;
  endfunction

  task automatic push(input logic [BW-1:0] d, input bit mode, input bit lit, input logic [BW-1:0] e);
    beat_t b;
    b.data = d; b.mode = mode; b.lit = lit; b.exp = e;
    src_q.push_back(b);
  endtask

  // drains src_q through the DUT; entered and left just after a falling edge
  task automatic run_stream(input bit rnd_v, input bit rnd_r, input int budget);
    int            cyc;
    logic          acc, ofire, stall;
    logic [BW-1:0] od;
    cyc = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0 || in_valid) && cyc < budget) begin
      if (!in_valid && src_q.size() > 0 && (!rnd_v || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        in_data  = src_q[0].data;
        in_mode  = src_q[0].mode;
      end
      out_ready = rnd_r ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      acc   = in_valid && in_ready;
      ofire = out_valid && out_ready;
      stall = out_valid && !out_ready;
      od    = out_data;
      chk("in_ready", BW'(in_ready), BW'(!stall));
      @(posedge clk);
      #1;
      if (acc) begin
        exp_q.push_back(src_q[0].lit ? src_q[0].exp : model(src_q[0].data, src_q[0].mode));
        src_q.pop_front();
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
      end
      if (ofire) begin
        chk("out_expected", BW'(exp_q.size() > 0), BW'(1));
        if (exp_q.size() > 0) chk("out_data", od, exp_q.pop_front());
      end
      if (stall) begin
        chk("stall_valid", BW'(out_valid), BW'(1));
        chk("stall_data", out_data, od);
      end
      @(negedge clk);
      cyc++;
    end
    chk("drain", BW'(src_q.size() + exp_q.size()), BW'(0));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 1'b1;
    in_data   = pack4(32'h0000_8000, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000);
    out_ready = 1'b1;

    // reset held two cycles with a beat offered
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", BW'(out_valid), BW'(0));
    chk("rst_out_data", out_data, BW'(0));
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", BW'(in_ready), BW'(1));

    // first beat after reset: four-lane vector, latency count
    in_data = pack4(32'h0000_8000, 32'hFFFF_8000, 32'h0005_0000, 32'h0000_0000);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat_edge1", BW'(out_valid), BW'(0));
    @(posedge clk); #1;
    chk("lat_edge2", BW'(out_valid), BW'(0));
    @(posedge clk); #1;
    chk("lat_edge3", BW'(out_valid), BW'(1));
    chk("lanes4_data", out_data, pack4(32'h0000_764D, 32'hFFFF_89B3, 32'h0001_0000, 32'h0000_0000));
    @(negedge clk);
    @(negedge clk);

    // directed points with values worked out by hand
    push(pack4(32'h0000_8000, 32'h0000_4000, 32'hFFFF_C000, 32'h0004_0000), 1'b1, 1'b1,
         pack4(32'h0000_764D, 32'h0000_3B26, 32'hFFFF_C4DA, 32'h0001_0000));
    push(pack4(32'h7FFF_FFFF, 32'h8000_0000, 32'h0003_FFFF, 32'hFFFC_0001), 1'b1, 1'b1,
         pack4(32'h0001_0000, 32'hFFFF_0000, 32'h0000_FFD3, 32'hFFFF_002D));
    push(pack4(32'h0000_C000, 32'h0002_0000, 32'hFFFE_0000, 32'h8000_0000), 1'b0, 1'b1,
         pack4(32'h0000_C000, 32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_0000));
    push(pack4(32'h0000_FFFF, 32'h0001_0000, 32'h0001_0001, 32'hFFFF_0001), 1'b0, 1'b1,
         pack4(32'h0000_FFFF, 32'h0001_0000, 32'h0001_0000, 32'hFFFF_0001));
    run_stream(1'b0, 1'b0, 200);

    // every segment, both signs, random fraction in each lane
    for (int k = 0; k < 8; k++) begin
      for (int rep = 0; rep < 2; rep++) begin
        logic [BW-1:0] d;
        for (int l = 0; l < L; l++) begin
          logic [31:0] xv;
          xv = 32'(k * 32768 + int'($urandom_range(0, 32767)));
          if ($urandom_range(0, 1) == 1) xv = -xv;
          d[l*DW +: DW] = xv;
        end
        push(d, 1'b1, 1'b0, '0);
      end
    end
    run_stream(1'b0, 1'b0, 400);

    // random traffic with bursty valid and toggling ready
    for (int i = 0; i < 40; i++)
      push(pack4(rand_x(), rand_x(), rand_x(), rand_x()), bit'($urandom_range(0, 1)), 1'b0, '0);
    run_stream(1'b1, 1'b1, 3000);

    // reset with a full, stalled pipeline: nothing may come out afterwards
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 1'b1;
    in_data   = pack4(rand_x(), rand_x(), rand_x(), rand_x());
    repeat (5) @(negedge clk);
    chk("prefill_valid", BW'(out_valid), BW'(1));
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", BW'(out_valid), BW'(0));
    chk("midrst_out_data", out_data, BW'(0));
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("flushed", BW'(out_valid), BW'(0));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
